// File: rtl/decode_stage_pkg.sv
// Shared types and constants for the RV32I decode stage.
//   inst_fetched_t : {valid, inst} word handed over by fetch
//   op_class_e     : major opcode class of a decoded instruction
//   decoded_inst_t : everything execute needs for one instruction
package decode_stage_pkg;

    localparam int          ARCH_LEN     = 32;
    localparam int          REG_ADDR_LEN = 5;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;  // addi x0,x0,0

    // RV32I major opcodes (inst[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // CLASS_NONE marks SYSTEM and every unsupported opcode.
    typedef enum logic [3:0] {
        CLASS_NONE   = 4'd0,
        CLASS_LUI    = 4'd1,
        CLASS_AUIPC  = 4'd2,
        CLASS_JAL    = 4'd3,
        CLASS_JALR   = 4'd4,
        CLASS_BRANCH = 4'd5,
        CLASS_LOAD   = 4'd6,
        CLASS_STORE  = 4'd7,
        CLASS_OPIMM  = 4'd8,
        CLASS_OP     = 4'd9,
        CLASS_FENCE  = 4'd10
    } op_class_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
    } inst_fetched_t;

    typedef struct packed {
        logic                    valid;
        logic [ARCH_LEN-1:0]     pc;
        logic [REG_ADDR_LEN-1:0] rs1;
        logic [REG_ADDR_LEN-1:0] rs2;
        logic [REG_ADDR_LEN-1:0] rd;
        logic [ARCH_LEN-1:0]     rs1_data;
        logic [ARCH_LEN-1:0]     rs2_data;
        logic [31:0]             imm;
        op_class_e               opclass;
        logic [2:0]              funct3;
        logic                    funct7b5;
        logic                    uses_rs1;
        logic                    uses_rs2;
        logic                    reg_write;
        logic                    mem_read;
        logic                    mem_write;
        logic                    illegal;
    } decoded_inst_t;

endpackage

// File: rtl/decode_stage_regfile.sv
// Integer register file: NREGS x ARCH_LEN, two asynchronous read ports,
// one synchronous write port with same-cycle write-to-read bypass.
//   clk            clock; write happens on posedge
//   we/waddr/wdata write port (writes to x0 are dropped)
//   raddr1/rdata1  read port 1
//   raddr2/rdata2  read port 2
module decode_stage_regfile
    import decode_stage_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [REG_ADDR_LEN-1:0] waddr,
    input  logic [ARCH_LEN-1:0]     wdata,
    input  logic [REG_ADDR_LEN-1:0] raddr1,
    output logic [ARCH_LEN-1:0]     rdata1,
    input  logic [REG_ADDR_LEN-1:0] raddr2,
    output logic [ARCH_LEN-1:0]     rdata2
);

    logic [ARCH_LEN-1:0] regs [NREGS];

    // NOTE: the storage array has no reset; clearing it would turn the RAM
    // into a wide flop bank. x0 is never written and is masked on read.
    always_ff @(posedge clk) begin
        if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    // Bypass lets decode see a value written back in the same cycle.
    assign rdata1 = (raddr1 == '0)                ? '0    :
                    (we && raddr1 == waddr)       ? wdata : regs[raddr1];
    assign rdata2 = (raddr2 == '0)                ? '0    :
                    (we && raddr2 == waddr)       ? wdata : regs[raddr2];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: F/D pipeline register, instruction decode, register
// file read and load-use hazard detection.
//   clk, rst                   clock, synchronous active-high reset
//   inst_fetched_in, pc_in     instruction word and its PC from fetch
//   br_tk                      taken branch from execute; squashes F/D
//   stall_dec_in               downstream stall; hold F/D, issue nothing
//   ex_valid_in/ex_mem_read_in/ex_rd_in  instruction currently in execute
//   wb_we_in/wb_rd_in/wb_data_in         register-file writeback port
//   dec_out                    decoded instruction to execute
//   stall_fet_out              freeze the fetch PC
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int                  NREGS   = 32,
    parameter logic [ARCH_LEN-1:0] BOOT_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  inst_fetched_t           inst_fetched_in,
    input  logic [ARCH_LEN-1:0]     pc_in,
    input  logic                    br_tk,
    input  logic                    stall_dec_in,
    input  logic                    ex_valid_in,
    input  logic                    ex_mem_read_in,
    input  logic [REG_ADDR_LEN-1:0] ex_rd_in,
    input  logic                    wb_we_in,
    input  logic [REG_ADDR_LEN-1:0] wb_rd_in,
    input  logic [ARCH_LEN-1:0]     wb_data_in,
    output decoded_inst_t           dec_out,
    output logic                    stall_fet_out
);

    logic                fd_valid;
    logic [31:0]         fd_inst;
    logic [ARCH_LEN-1:0] fd_pc;

    logic hazard;
    logic stall;
    logic issue;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            fd_valid <= 1'b0;
            fd_inst  <= NOP_INST;
            fd_pc    <= BOOT_PC;
        end else if (br_tk) begin
            fd_valid <= 1'b0;
        end else if (!stall) begin
            fd_valid <= inst_fetched_in.valid;
            fd_inst  <= inst_fetched_in.inst;
            fd_pc    <= pc_in;
        end
    end

    // Instruction fields and immediate formats
    logic [6:0]              opcode;
    logic [REG_ADDR_LEN-1:0] rd, rs1, rs2;
    logic [31:0]             imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = fd_inst[6:0];
    assign rd     = fd_inst[11:7];
    assign rs1    = fd_inst[19:15];
    assign rs2    = fd_inst[24:20];

    assign imm_i = {{20{fd_inst[31]}}, fd_inst[31:20]};
    assign imm_s = {{20{fd_inst[31]}}, fd_inst[31:25], fd_inst[11:7]};
    assign imm_b = {{19{fd_inst[31]}}, fd_inst[31], fd_inst[7], fd_inst[30:25],
                    fd_inst[11:8], 1'b0};
    assign imm_u = {fd_inst[31:12], 12'b0};
    assign imm_j = {{11{fd_inst[31]}}, fd_inst[31], fd_inst[19:12], fd_inst[20],
                    fd_inst[30:21], 1'b0};

    op_class_e   opclass;
    logic [31:0] imm;
    logic        uses_rs1, uses_rs2, writes_rd, is_load, is_store, illegal;

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned (which would infer a latch).
    always_comb begin
        opclass   = CLASS_NONE;
        imm       = '0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OPC_LUI:    begin opclass = CLASS_LUI;   imm = imm_u; writes_rd = 1'b1; end
            OPC_AUIPC:  begin opclass = CLASS_AUIPC; imm = imm_u; writes_rd = 1'b1; end
            OPC_JAL:    begin opclass = CLASS_JAL;   imm = imm_j; writes_rd = 1'b1; end
            OPC_JALR:   begin
                opclass = CLASS_JALR; imm = imm_i; uses_rs1 = 1'b1; writes_rd = 1'b1;
            end
            OPC_BRANCH: begin
                opclass = CLASS_BRANCH; imm = imm_b; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            OPC_LOAD:   begin
                opclass = CLASS_LOAD; imm = imm_i; uses_rs1 = 1'b1;
                writes_rd = 1'b1; is_load = 1'b1;
            end
            OPC_STORE:  begin
                opclass = CLASS_STORE; imm = imm_s; uses_rs1 = 1'b1;
                uses_rs2 = 1'b1; is_store = 1'b1;
            end
            OPC_OPIMM:  begin
                opclass = CLASS_OPIMM; imm = imm_i; uses_rs1 = 1'b1; writes_rd = 1'b1;
            end
            OPC_OP:     begin
                opclass = CLASS_OP; uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1;
            end
            // FENCE is treated as a NOP: no register write, no memory access.
            OPC_FENCE:  begin opclass = CLASS_FENCE; imm = imm_i; end
            default:    illegal = 1'b1;  // SYSTEM and unsupported opcodes
        endcase
    end

    logic [ARCH_LEN-1:0] rs1_data, rs2_data;

    decode_stage_regfile #(.NREGS(NREGS)) u_regfile (
        .clk    (clk),
        .we     (wb_we_in),
        .waddr  (wb_rd_in),
        .wdata  (wb_data_in),
        .raddr1 (rs1),
        .rdata1 (rs1_data),
        .raddr2 (rs2),
        .rdata2 (rs2_data)
    );

    // The load ahead of us produces its data too late to forward, so hold
    // one cycle; execute then holds a bubble and the hazard clears itself.
    assign hazard = fd_valid & ex_valid_in & ex_mem_read_in & (ex_rd_in != '0) &
                    ((uses_rs1 & (rs1 == ex_rd_in)) | (uses_rs2 & (rs2 == ex_rd_in)));
    assign stall  = hazard | stall_dec_in;
    assign issue  = fd_valid & ~stall & ~br_tk;

    // A taken branch redirects fetch, so it overrides any stall request.
    assign stall_fet_out = stall & ~br_tk & ~rst;

    // An empty F/D presents an all-zero packet; a held or squashed valid
    // instruction keeps its fields but has every side-effect flag cleared.
    always_comb begin
        dec_out = '0;
        if (fd_valid) begin
            dec_out.valid     = issue;
            dec_out.pc        = fd_pc;
            dec_out.rs1       = rs1;
            dec_out.rs2       = rs2;
            dec_out.rd        = rd;
            dec_out.rs1_data  = rs1_data;
            dec_out.rs2_data  = rs2_data;
            dec_out.imm       = imm;
            dec_out.opclass   = opclass;
            dec_out.funct3    = fd_inst[14:12];
            dec_out.funct7b5  = fd_inst[30];
            dec_out.uses_rs1  = uses_rs1;
            dec_out.uses_rs2  = uses_rs2;
            dec_out.reg_write = issue & writes_rd & (rd != '0);
            dec_out.mem_read  = issue & is_load;
            dec_out.mem_write = issue & is_store;
            dec_out.illegal   = issue & illegal;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural model that tracks
// the F/D contents and the architectural register values.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic          clk;
    logic          rst;
    logic          f_valid;
    logic [31:0]   f_inst;
    logic [31:0]   pc_in;
    logic          br_tk;
    logic          stall_dec;
    logic          ex_valid;
    logic          ex_mem_read;
    logic [4:0]    ex_rd;
    logic          wb_we;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    decoded_inst_t dec_out;
    logic          stall_fet_out;

    decode_stage #(.NREGS(32), .BOOT_PC(32'h0)) dut (
        .clk             (clk),
        .rst             (rst),
        .inst_fetched_in ({f_valid, f_inst}),
        .pc_in           (pc_in),
        .br_tk           (br_tk),
        .stall_dec_in    (stall_dec),
        .ex_valid_in     (ex_valid),
        .ex_mem_read_in  (ex_mem_read),
        .ex_rd_in        (ex_rd),
        .wb_we_in        (wb_we),
        .wb_rd_in        (wb_rd),
        .wb_data_in      (wb_data),
        .dec_out         (dec_out),
        .stall_fet_out   (stall_fet_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] rf_m [32];
    bit          m_known = 0;
    logic        m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_pc;
    bit          m_hz;

    function automatic op_class_e ref_class(input logic [31:0] w);
        case (w[6:0])
            7'h37:   return CLASS_LUI;
            7'h17:   return CLASS_AUIPC;
            7'h6F:   return CLASS_JAL;
            7'h67:   return CLASS_JALR;
            7'h63:   return CLASS_BRANCH;
            7'h03:   return CLASS_LOAD;
            7'h23:   return CLASS_STORE;
            7'h13:   return CLASS_OPIMM;
            7'h33:   return CLASS_OP;
            7'h0F:   return CLASS_FENCE;
            default: return CLASS_NONE;
        endcase
    endfunction

    // Immediates rebuilt by signed arithmetic on the whole word.
    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        int s;
        int b;
        s = w;
        case (w[6:0])
            7'h67, 7'h03, 7'h13, 7'h0F: b = s >>> 20;
            7'h23: b = ((s >>> 25) * 32) + int'(w[11:7]);
            7'h63: b = ((s >>> 31) * 4096) + int'(w[7]) * 2048 +
                       int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            7'h6F: b = ((s >>> 31) * 1048576) + int'(w[19:12]) * 4096 +
                       int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            7'h37, 7'h17: b = int'(w & 32'hFFFF_F000);
            default: b = 0;
        endcase
        return b;
    endfunction

    function automatic logic [31:0] ref_read(input int idx);
        if (idx == 0) return 32'h0;
        if (wb_we && int'(wb_rd) == idx) return wb_data;
        return rf_m[idx];
    endfunction

    task automatic check_outputs();
        op_class_e c;
        bit r1, r2, wr, ev;
        int rs1, rs2, rd;
        if (!m_known) begin
            m_hz = 0;
            return;
        end
        c   = ref_class(m_inst);
        rs1 = m_inst[19:15];
        rs2 = m_inst[24:20];
        rd  = m_inst[11:7];
        r1  = c inside {CLASS_JALR, CLASS_BRANCH, CLASS_LOAD, CLASS_STORE, CLASS_OPIMM, CLASS_OP};
        r2  = c inside {CLASS_BRANCH, CLASS_STORE, CLASS_OP};
        wr  = c inside {CLASS_LUI, CLASS_AUIPC, CLASS_JAL, CLASS_JALR, CLASS_LOAD, CLASS_OPIMM, CLASS_OP};
        m_hz = m_valid && ex_valid && ex_mem_read && ex_rd != 0 &&
               ((r1 && rs1 == int'(ex_rd)) || (r2 && rs2 == int'(ex_rd)));
        ev = m_valid && !m_hz && !stall_dec && !br_tk;
        check("stall_fet", stall_fet_out, (m_hz || stall_dec) && !br_tk && !rst);
        check("valid", dec_out.valid, ev);
        check("reg_write", dec_out.reg_write, ev && wr && rd != 0);
        check("mem_read", dec_out.mem_read, ev && c == CLASS_LOAD);
        check("mem_write", dec_out.mem_write, ev && c == CLASS_STORE);
        if (m_valid) begin
            check("pc", dec_out.pc, m_pc);
            check("rd", dec_out.rd, rd);
            check("rs1", dec_out.rs1, rs1);
            check("rs2", dec_out.rs2, rs2);
            check("funct3", dec_out.funct3, m_inst[14:12]);
            check("funct7b5", dec_out.funct7b5, m_inst[30]);
            if (c != CLASS_NONE) check("opclass", dec_out.opclass, c);
            if (c != CLASS_NONE && c != CLASS_OP) check("imm", dec_out.imm, ref_imm(m_inst));
            if (ev) check("illegal", dec_out.illegal, c == CLASS_NONE);
            if (r1) check("rs1_data", dec_out.rs1_data, ref_read(rs1));
            if (r2) check("rs2_data", dec_out.rs2_data, ref_read(rs2));
        end
    endtask

    // Check the settled outputs, then advance one clock and update the model.
    task automatic cycle();
        bit          n_known;
        logic        n_valid;
        logic [31:0] n_inst, n_pc;
        #1;
        check_outputs();
        n_known = m_known;
        n_valid = m_valid;
        n_inst  = m_inst;
        n_pc    = m_pc;
        if (rst) begin
            n_known = 1;
            n_valid = 0;
            n_inst  = 32'h0000_0013;
            n_pc    = 32'h0;
        end else if (br_tk) begin
            n_valid = 0;
        end else if (!(m_hz || stall_dec)) begin
            n_valid = f_valid;
            n_inst  = f_inst;
            n_pc    = pc_in;
        end
        if (wb_we && wb_rd != 0) rf_m[wb_rd] = wb_data;
        @(posedge clk);
        #1;
        m_known = n_known;
        m_valid = n_valid;
        m_inst  = n_inst;
        m_pc    = n_pc;
    endtask

    logic [31:0] imm_tbl_inst [4] = '{32'hFE00_0EE3, 32'h0080_006F, 32'h1234_5037, 32'h0011_2223};
    logic [31:0] imm_tbl_exp  [4] = '{32'hFFFF_FFFC, 32'h0000_0008, 32'h1234_5000, 32'h0000_0004};
    logic [6:0]  op_pool [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                  7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; f_valid = 0; f_inst = 0; pc_in = 0; br_tk = 0; stall_dec = 0;
        ex_valid = 0; ex_mem_read = 0; ex_rd = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
        @(posedge clk); #1;
        cycle();
        cycle();
        rst = 0;
        #1;
        check("reset_dec_zero", dec_out, '0);
        check("reset_stall", stall_fet_out, 1'b0);
        cycle();

        // Give every register a known value.
        for (int i = 1; i < 32; i++) begin
            wb_we = 1; wb_rd = 5'(i); wb_data = $urandom;
            cycle();
        end
        wb_we = 0;

        // addi x1,x0,5
        f_valid = 1; f_inst = 32'h0050_0093; pc_in = 32'h0;
        cycle();
        f_valid = 0;
        #1;
        check("t1_valid", dec_out.valid, 1'b1);
        check("t1_rd", dec_out.rd, 5'd1);
        check("t1_imm", dec_out.imm, 32'd5);
        check("t1_reg_write", dec_out.reg_write, 1'b1);
        check("t1_rs1_data", dec_out.rs1_data, 32'h0);
        cycle();

        // add x6,x5,x0 with x5 written back in the decode cycle
        f_valid = 1; f_inst = 32'h0002_8333; pc_in = 32'h4;
        cycle();
        f_valid = 0; wb_we = 1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        #1;
        check("t2_bypass", dec_out.rs1_data, 32'hDEAD_BEEF);
        cycle();
        wb_rd = 5'd0; wb_data = 32'h1234_5678;
        cycle();
        wb_we = 0;
        f_valid = 1; f_inst = 32'h0000_03B3; pc_in = 32'h8;  // add x7,x0,x0
        cycle();
        f_valid = 0;
        #1;
        check("t2_x0_rs1", dec_out.rs1_data, 32'h0);
        check("t2_x0_rs2", dec_out.rs2_data, 32'h0);
        cycle();

        // load-use: lw x2 in execute, add x3,x2,x1 in decode
        f_valid = 1; f_inst = 32'h0011_01B3; pc_in = 32'hC;
        cycle();
        f_inst = 32'h0050_0093; pc_in = 32'h10;
        ex_valid = 1; ex_mem_read = 1; ex_rd = 5'd2;
        #1;
        check("t3_stall", stall_fet_out, 1'b1);
        check("t3_bubble", dec_out.valid, 1'b0);
        cycle();
        ex_valid = 0; ex_mem_read = 0; ex_rd = 0;
        #1;
        check("t3_release_valid", dec_out.valid, 1'b1);
        check("t3_release_pc", dec_out.pc, 32'hC);
        check("t3_release_stall", stall_fet_out, 1'b0);
        cycle();

        // taken branch beats a downstream stall
        br_tk = 1; stall_dec = 1;
        #1;
        check("t4_stall_fet", stall_fet_out, 1'b0);
        check("t4_valid", dec_out.valid, 1'b0);
        cycle();
        br_tk = 0; stall_dec = 0;
        f_valid = 1; f_inst = 32'h0070_0193; pc_in = 32'h40;  // addi x3,x0,7
        #1;
        check("t4_squashed", dec_out.valid, 1'b0);
        cycle();
        f_valid = 0;
        #1;
        check("t4_after_valid", dec_out.valid, 1'b1);
        check("t4_after_pc", dec_out.pc, 32'h40);
        check("t4_after_imm", dec_out.imm, 32'd7);
        cycle();

        // immediate formats
        for (int i = 0; i <= 4; i++) begin
            f_valid = (i < 4);
            f_inst  = (i < 4) ? imm_tbl_inst[i] : 32'h0;
            pc_in   = 32'h50 + 32'(i * 4);
            #1;
            if (i > 0) check("t5_imm", dec_out.imm, imm_tbl_exp[i-1]);
            cycle();
        end

        // ecall is illegal
        f_valid = 1; f_inst = 32'h0000_0073; pc_in = 32'h60;
        cycle();
        f_valid = 0;
        #1;
        check("t6_illegal", dec_out.illegal, 1'b1);
        check("t6_no_write", dec_out.reg_write, 1'b0);
        check("t6_valid", dec_out.valid, 1'b1);
        cycle();

        // reset during a load-use stall
        f_valid = 1; f_inst = 32'h0011_01B3; pc_in = 32'h64;
        cycle();
        f_inst = 32'h0050_0093; pc_in = 32'h68;
        ex_valid = 1; ex_mem_read = 1; ex_rd = 5'd2;
        #1;
        check("t6_pre_stall", stall_fet_out, 1'b1);
        cycle();
        rst = 1;
        #1;
        check("t6_rst_stall", stall_fet_out, 1'b0);
        cycle();
        rst = 0;
        #1;
        check("t6_post_stall", stall_fet_out, 1'b0);
        check("t6_post_valid", dec_out.valid, 1'b0);
        cycle();
        ex_valid = 0; ex_mem_read = 0; ex_rd = 0; f_valid = 0;
        cycle();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] w;
            w        = $urandom;
            w[6:0]   = op_pool[$urandom_range(0, 11)];
            f_valid  = ($urandom_range(0, 3) != 0);
            f_inst   = w;
            pc_in    = {$urandom_range(0, 16383), 2'b00};
            rst      = ($urandom_range(0, 49) == 0);
            br_tk    = ($urandom_range(0, 9) == 0);
            stall_dec = ($urandom_range(0, 5) == 0);
            ex_valid    = $urandom_range(0, 1);
            ex_mem_read = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 2))
                0:       ex_rd = m_inst[19:15];
                1:       ex_rd = m_inst[24:20];
                default: ex_rd = 5'($urandom_range(0, 31));
            endcase
            wb_we   = $urandom_range(0, 1);
            wb_rd   = ($urandom_range(0, 1) != 0) ? m_inst[19:15] : 5'($urandom_range(0, 31));
            wb_data = $urandom;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
